io_uart_tx: RTL

Memory-mapped, FIFO-buffered UART transmitter for the J1 I/O bus, the successor to the single-byte busy-flag UART path. It decodes one 4 KB I/O region, accepts bytes into a parametrised FIFO and serialises them 8N1 at a runtime-programmable baud divider. Software streams bytes without per-byte polling. Its status word keeps bit 0 as a "cannot accept" flag, so existing busy-polling firmware still works.

---
 rtl/io_uart_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/io_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter on the J1 I/O bus.
// Status bit 0 stays "cannot accept" so busy-polling firmware still works.
module io_uart_tx #(
    parameter logic [3:0]  BASE       = 4'hF,
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] BAUD_DIV   = 16'd433
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [15:0] io_rdata,
    output logic        tx
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           div_q, div_d;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            sh_q, sh_d;
    logic                  tx_q, tx_d;

    logic                  sel, wr, push, push_ok, flush, ovf_clr, pop;
    logic                  full, empty, busy;
    logic [1:0]            off;
    logic [7:0]            head;
    logic                  unused;

    assign sel     = (io_addr[15:12] == BASE);
    assign off     = io_addr[1:0];
    assign wr      = io_we & sel;
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign busy    = (state_q != IDLE);
    assign push    = wr && (off == 2'd0);
    assign push_ok = push && !full;
    assign flush   = wr && (off == 2'd2) && io_wdata[0];
    assign ovf_clr = wr && (off == 2'd2) && io_wdata[1];
    assign head    = mem_q[rptr_q];
    assign tx      = tx_q;
    assign unused  = ^{io_re, io_addr[11:2]};

    always_comb begin
        io_rdata = 16'h0000;
        if (sel) begin
            unique case (off)
                2'd0: io_rdata = {8'(level_q), 4'b0000,
                                  ovf_q, busy, empty, full};
                2'd1: io_rdata = div_q;
                2'd2: io_rdata = 16'(DEPTH);
                default: io_rdata = 16'h0000;
            endcase
        end
    end

    // Flush takes priority over a same-cycle pop; the popped byte still ships.
    always_comb begin
        wptr_d  = wptr_q + DEPTH_LOG2'(push_ok);
        rptr_d  = flush ? wptr_q : rptr_q + DEPTH_LOG2'(pop);
        level_d = flush ? '0 : level_q + LW'(push_ok) - LW'(pop);
        ovf_d   = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (push && full)
            ovf_d = 1'b1;
        div_d   = (wr && off == 2'd1) ? io_wdata : div_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= io_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= BAUD_DIV;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    cnt_d   = div_q;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d   = div_q;
                    tx_d    = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d  = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next start bit when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = head;
                        cnt_d   = div_q;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

endmodule
